// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store stage.
// One request is latched at a time and served as IDLE -> ACCESS -> RESP.
module mem_port_arbiter #(
  parameter int unsigned ADDR_BITS    = 32,
  parameter int unsigned DATA_BITS    = 32,
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ifReq,
  input  logic [ADDR_BITS-1:0] ifAddr,
  output logic [DATA_BITS-1:0] ifRdata,
  output logic                 ifDone,
  output logic                 ifStall,
  input  logic                 dmReq,
  input  logic                 dmWrEn,
  input  logic [ADDR_BITS-1:0] dmAddr,
  input  logic [DATA_BITS-1:0] dmWdata,
  output logic [DATA_BITS-1:0] dmRdata,
  output logic                 dmDone,
  output logic                 dmStall,
  output logic [ADDR_BITS-1:0] memAddr,
  output logic                 memWrEn,
  output logic [DATA_BITS-1:0] memWdata,
  input  logic [DATA_BITS-1:0] memRdata,
  output logic [1:0]           owner,
  output logic                 busy
);

  localparam int unsigned WAIT_W   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_IF   = 2'd1;
  localparam logic [1:0] OWNER_DM   = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateType;

  stateType              state;
  logic [WAIT_W-1:0]     waitCnt;
  logic [STARVE_W-1:0]   starveCnt;
  logic                  latchedWr;
  logic                  starved;
  logic                  pickDm;

  // DM has priority unless fetch has been passed over STARVE_LIMIT times in a row
  assign starved = (starveCnt == STARVE_W'(STARVE_LIMIT));
  assign pickDm  = dmReq & ~(ifReq & starved);

  assign ifStall = ifReq & ~ifDone;
  assign dmStall = dmReq & ~dmDone;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      waitCnt   <= '0;
      starveCnt <= '0;
      latchedWr <= 1'b0;
      ifRdata   <= '0;
      ifDone    <= 1'b0;
      dmRdata   <= '0;
      dmDone    <= 1'b0;
      memAddr   <= '0;
      memWrEn   <= 1'b0;
      memWdata  <= '0;
      owner     <= OWNER_NONE;
      busy      <= 1'b0;
    end else begin
      ifDone  <= 1'b0;
      dmDone  <= 1'b0;
      memWrEn <= 1'b0;
      case (state)
        IDLE: begin
          if (pickDm) begin
            memAddr   <= dmAddr;
            memWrEn   <= dmWrEn;
            memWdata  <= dmWdata;
            latchedWr <= dmWrEn;
            owner     <= OWNER_DM;
            busy      <= 1'b1;
            waitCnt   <= WAIT_W'(WAIT_CYCLES);
            state     <= ACCESS;
            // Saturation is implicit: a starved fetch wins instead of counting further
            if (ifReq) starveCnt <= starveCnt + STARVE_W'(1);
          end else if (ifReq) begin
            memAddr   <= ifAddr;
            latchedWr <= 1'b0;
            owner     <= OWNER_IF;
            busy      <= 1'b1;
            waitCnt   <= WAIT_W'(WAIT_CYCLES);
            starveCnt <= '0;
            state     <= ACCESS;
          end else begin
            owner <= OWNER_NONE;
          end
        end
        ACCESS: begin
          if (waitCnt == '0) begin
            if (owner == OWNER_IF) begin
              ifRdata <= memRdata;
              ifDone  <= 1'b1;
            end else begin
              if (!latchedWr) dmRdata <= memRdata;
              dmDone <= 1'b1;
            end
            state <= RESP;
          end else begin
            waitCnt <= waitCnt - WAIT_W'(1);
          end
        end
        RESP: begin
          owner <= OWNER_NONE;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          owner <= OWNER_NONE;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations (one WAIT_CYCLES=0 instance).
module tb_mem_port_arbiter;

  localparam int W     = 1;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ifReq = 1'b0;
  logic [31:0] ifAddr = '0;
  logic        dmReq = 1'b0;
  logic        dmWrEn = 1'b0;
  logic [31:0] dmAddr = '0;
  logic [31:0] dmWdata = '0;
  logic [31:0] memRdata = '0;

  logic [31:0] ifRdata, dmRdata, memAddr, memWdata;
  logic        ifDone, ifStall, dmDone, dmStall, memWrEn, busy;
  logic [1:0]  owner;

  logic [31:0] ifRdataZ, dmRdataZ, memAddrZ, memWdataZ;
  logic        ifDoneZ, ifStallZ, dmDoneZ, dmStallZ, memWrEnZ, busyZ;
  logic [1:0]  ownerZ;

  int tests = 0;
  int fails = 0;
  bit checkOn = 1'b0;

  mem_port_arbiter #(.ADDR_BITS(32), .DATA_BITS(32), .WAIT_CYCLES(W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifDone(ifDone), .ifStall(ifStall),
    .dmReq(dmReq), .dmWrEn(dmWrEn), .dmAddr(dmAddr), .dmWdata(dmWdata),
    .dmRdata(dmRdata), .dmDone(dmDone), .dmStall(dmStall),
    .memAddr(memAddr), .memWrEn(memWrEn), .memWdata(memWdata), .memRdata(memRdata),
    .owner(owner), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_BITS(32), .DATA_BITS(32), .WAIT_CYCLES(0), .STARVE_LIMIT(LIMIT)) dutZ (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdataZ), .ifDone(ifDoneZ), .ifStall(ifStallZ),
    .dmReq(dmReq), .dmWrEn(dmWrEn), .dmAddr(dmAddr), .dmWdata(dmWdata),
    .dmRdata(dmRdataZ), .dmDone(dmDoneZ), .dmStall(dmStallZ),
    .memAddr(memAddrZ), .memWrEn(memWrEnZ), .memWdata(memWdataZ), .memRdata(memRdata),
    .owner(ownerZ), .busy(busyZ)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Transaction model: an access granted in cycle g occupies cycles g+1..g+W+2,
  // with data sampled at the end of cycle g+W+1 and done shown in cycle g+W+2.
  int          cyc = 0;
  int          gCyc = 0;
  bit          haveTx = 1'b0;
  int          txWho = 0;
  bit          txWr = 1'b0;
  logic [31:0] mMemAddr = '0, mMemWdata = '0, mIfRdata = '0, mDmRdata = '0;
  int          starve = 0;

  always @(posedge clk or posedge reset) begin : model
    int k;
    if (reset) begin
      haveTx = 1'b0; txWho = 0; txWr = 1'b0; starve = 0;
      mMemAddr = '0; mMemWdata = '0; mIfRdata = '0; mDmRdata = '0;
    end else begin
      k = cyc - gCyc;
      if (!haveTx || k > W + 2) begin
        if (dmReq && !(ifReq && starve == LIMIT)) begin
          haveTx = 1'b1; gCyc = cyc; txWho = 2; txWr = dmWrEn;
          mMemAddr = dmAddr; mMemWdata = dmWdata;
          if (ifReq && starve < LIMIT) starve = starve + 1;
        end else if (ifReq) begin
          haveTx = 1'b1; gCyc = cyc; txWho = 1; txWr = 1'b0;
          mMemAddr = ifAddr; starve = 0;
        end
      end else if (k == W + 1 && !txWr) begin
        if (txWho == 1) mIfRdata = memRdata;
        else            mDmRdata = memRdata;
      end
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin : compare
    int k;
    bit act, doneNow;
    int ownE;
    if (checkOn) begin
      k       = cyc - gCyc;
      act     = haveTx && k >= 1 && k <= W + 2;
      doneNow = haveTx && k == W + 2;
      ownE    = act ? txWho : 0;
      check("owner", 32'(owner), 32'(ownE));
      check("busy", 32'(busy), 32'(act));
      check("memWrEn", 32'(memWrEn), 32'(haveTx && txWr && k == 1));
      check("memAddr", memAddr, mMemAddr);
      check("memWdata", memWdata, mMemWdata);
      check("ifDone", 32'(ifDone), 32'(doneNow && txWho == 1));
      check("dmDone", 32'(dmDone), 32'(doneNow && txWho == 2));
      check("ifRdata", ifRdata, mIfRdata);
      check("dmRdata", dmRdata, mDmRdata);
      check("ifStall", 32'(ifStall), 32'(ifReq && !(doneNow && txWho == 1)));
      check("dmStall", 32'(dmStall), 32'(dmReq && !(doneNow && txWho == 2)));
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int expOwn[10];
    expOwn = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    checkOn = 1'b1;
    @(negedge clk);
    check("reset owner", 32'(owner), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset memAddr", memAddr, 32'd0);
    tick();
    tick();

    // 1: fetch only
    ifAddr = 32'h40; memRdata = 32'h1234; ifReq = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) ifReq = 1'b0;
      @(negedge clk);
      if (c <= 2) check("t1 ifStall", 32'(ifStall), 32'd1);
      if (c == 1 || c == 2) check("t1 memAddr", memAddr, 32'h40);
      if (c == 3) begin
        check("t1 ifDone", 32'(ifDone), 32'd1);
        check("t1 ifRdata", ifRdata, 32'h1234);
      end
      tick();
    end

    // 2: simultaneous requests, DM first then IF
    ifReq = 1'b1; ifAddr = 32'h44; dmReq = 1'b1; dmWrEn = 1'b0; dmAddr = 32'h80; memRdata = 32'h5555;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) dmReq = 1'b0;
      if (c == 4) memRdata = 32'h6666;
      if (c == 7) ifReq = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        check("t2 owner dm", 32'(owner), 32'd2);
        check("t2 memAddr dm", memAddr, 32'h80);
      end
      if (c == 3) begin
        check("t2 dmDone", 32'(dmDone), 32'd1);
        check("t2 dmRdata", dmRdata, 32'h5555);
        check("t2 ifDone early", 32'(ifDone), 32'd0);
        check("t2 ifStall", 32'(ifStall), 32'd1);
      end
      if (c == 4) check("t2 owner idle", 32'(owner), 32'd0);
      if (c == 5) begin
        check("t2 owner if", 32'(owner), 32'd1);
        check("t2 memAddr if", memAddr, 32'h44);
      end
      if (c == 7) begin
        check("t2 ifDone", 32'(ifDone), 32'd1);
        check("t2 ifRdata", ifRdata, 32'h6666);
      end
      tick();
    end

    // 3: store, with inputs changing mid-access
    dmReq = 1'b1; dmWrEn = 1'b1; dmAddr = 32'h100; dmWdata = 32'hDEAD; memRdata = 32'h9999;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin dmAddr = 32'h999; dmWdata = 32'h0; end
      if (c == 3) begin dmReq = 1'b0; dmWrEn = 1'b0; end
      @(negedge clk);
      check("t3 memWrEn", 32'(memWrEn), 32'(c == 1));
      if (c == 1) begin
        check("t3 memWdata", memWdata, 32'hDEAD);
        check("t3 memAddr", memAddr, 32'h100);
      end
      if (c == 3) begin
        check("t3 dmDone", 32'(dmDone), 32'd1);
        check("t3 dmRdata kept", dmRdata, 32'h5555);
      end
      if (c == 4) begin
        check("t3 memAddr hold", memAddr, 32'h100);
        check("t3 memWdata hold", memWdata, 32'hDEAD);
      end
      tick();
    end

    // 4: both held high, fetch forced after LIMIT data grants
    ifReq = 1'b1; ifAddr = 32'h48; dmReq = 1'b1; dmWrEn = 1'b0; dmAddr = 32'h180; memRdata = 32'h4444;
    for (int c = 0; c < 40; c++) begin
      if (c == 39) begin ifReq = 1'b0; dmReq = 1'b0; end
      @(negedge clk);
      if (c % 4 == 1) check("t4 grant order", 32'(owner), 32'(expOwn[c / 4]));
      tick();
    end

    // 5: reset in the middle of a store
    dmReq = 1'b1; dmWrEn = 1'b1; dmAddr = 32'h200; dmWdata = 32'hBEEF;
    tick();
    @(negedge clk);
    check("t5 memWrEn before", 32'(memWrEn), 32'd1);
    check("t5 owner before", 32'(owner), 32'd2);
    #1 reset = 1'b1; dmReq = 1'b0; dmWrEn = 1'b0;
    #1;
    check("t5 memWrEn async", 32'(memWrEn), 32'd0);
    check("t5 owner async", 32'(owner), 32'd0);
    check("t5 busy async", 32'(busy), 32'd0);
    check("t5 memAddr async", memAddr, 32'd0);
    #1 reset = 1'b0;
    tick();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t5 no done", 32'(dmDone), 32'd0);
      tick();
    end
    dmAddr = 32'h300; memRdata = 32'h7777; dmReq = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) dmReq = 1'b0;
      @(negedge clk);
      if (c == 3) begin
        check("t5 dmDone after", 32'(dmDone), 32'd1);
        check("t5 dmRdata after", dmRdata, 32'h7777);
      end
      tick();
    end
    repeat (4) tick();

    // 6: zero wait states on the second instance
    dmReq = 1'b1; dmWrEn = 1'b0; dmAddr = 32'h20; memRdata = 32'hABCD;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) dmReq = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        check("t6 owner", 32'(ownerZ), 32'd2);
        check("t6 memAddr", memAddrZ, 32'h20);
        check("t6 busy", 32'(busyZ), 32'd1);
        check("t6 memWrEn", 32'(memWrEnZ), 32'd0);
        check("t6 dmStall", 32'(dmStallZ), 32'd1);
        check("t6 memWdata", memWdataZ, 32'hBEEF);
        check("t6 ifRdata", ifRdataZ, 32'd0);
      end
      if (c == 2) begin
        check("t6 dmDone", 32'(dmDoneZ), 32'd1);
        check("t6 dmRdata", dmRdataZ, 32'hABCD);
        check("t6 ifDone", 32'(ifDoneZ), 32'd0);
        check("t6 ifStall", 32'(ifStallZ), 32'd0);
      end
      if (c == 3) begin
        check("t6 idle", 32'(busyZ), 32'd0);
        check("t6 done cleared", 32'(dmDoneZ), 32'd0);
      end
      tick();
    end
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
